// File: rtl/lcd_write_sequencer.sv
// HD44780-style write-only sequencer: autonomous power-up init from a small ROM,
// then one command/data byte per valid/ready handshake with fixed setup/EN/hold/exec waits.
module lcd_write_sequencer #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_SU    = 2,
  parameter int T_EN    = 25,
  parameter int T_HOLD  = 2,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rs,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        init_done,
  output logic [10:0] lcd_export,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE after init, and cmd_rs/cmd_data are sampled on that edge only.

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_PWRUP, T_INIT1), max2(T_INIT2, T_SU)),
                              max2(max2(T_EN, T_HOLD), max2(T_CMD, T_CLR)));
  localparam int CW = $clog2(T_MAX + 1);

  // The counter holds "remaining cycles minus one" so a state lasts exactly T cycles.
  localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] L_INIT2 = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] L_SU    = CW'(T_SU - 1);
  localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(T_CLR - 1);

  typedef enum logic [2:0] {
    S_PWRUP  = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4,
    S_IDLE   = 3'd5
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h38;
      3'd4:             init_byte = 8'h0C;
      3'd5:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt, w_wait_load;
  logic [2:0]      r_idx, w_nxt_idx;
  logic            r_init_done, w_nxt_done;
  logic            r_rs, w_nxt_rs;
  logic [7:0]      r_data, w_nxt_data;
  logic            r_en, r_ready, r_busy;
  logic            w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_wait_load = L_CMD;
    if (!r_init_done) begin
      case (r_idx)
        3'd0:    w_wait_load = L_INIT1;
        3'd1:    w_wait_load = L_INIT2;
        3'd5:    w_wait_load = L_CLR;
        default: w_wait_load = L_CMD;
      endcase
    end else if (!r_rs && r_data[7:1] == 7'b0000000 && r_data[0]) begin
      w_wait_load = L_CLR;
    end else if (!r_rs && r_data[7:1] == 7'b0000001) begin
      w_wait_load = L_CLR;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt - CW'(1);
    w_nxt_idx   = r_idx;
    w_nxt_done  = r_init_done;
    w_nxt_rs    = r_rs;
    w_nxt_data  = r_data;
    case (r_state)
      S_PWRUP: if (w_cnt_zero) begin
        w_nxt_state = S_SETUP;
        w_nxt_cnt   = L_SU;
        w_nxt_idx   = 3'd0;
        w_nxt_rs    = 1'b0;
        w_nxt_data  = init_byte(3'd0);
      end
      S_SETUP: if (w_cnt_zero) begin
        w_nxt_state = S_ENABLE;
        w_nxt_cnt   = L_EN;
      end
      S_ENABLE: if (w_cnt_zero) begin
        w_nxt_state = S_HOLD;
        w_nxt_cnt   = L_HOLD;
      end
      S_HOLD: if (w_cnt_zero) begin
        w_nxt_state = S_WAIT;
        w_nxt_cnt   = w_wait_load;
      end
      S_WAIT: if (w_cnt_zero) begin
        if (r_init_done) begin
          w_nxt_state = S_IDLE;
        end else if (r_idx == 3'd6) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state = S_SETUP;
          w_nxt_cnt   = L_SU;
          w_nxt_idx   = r_idx + 3'd1;
          w_nxt_rs    = 1'b0;
          w_nxt_data  = init_byte(r_idx + 3'd1);
        end
      end
      S_IDLE: begin
        w_nxt_cnt = r_cnt;
        if (cmd_valid && r_ready) begin
          w_nxt_state = S_SETUP;
          w_nxt_cnt   = L_SU;
          w_nxt_rs    = cmd_rs;
          w_nxt_data  = cmd_data;
        end
      end
      default: begin
        w_nxt_state = S_PWRUP;
        w_nxt_cnt   = L_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= L_PWRUP;
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_en        <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_idx       <= w_nxt_idx;
      r_init_done <= w_nxt_done;
      r_rs        <= w_nxt_rs;
      r_data      <= w_nxt_data;
      r_en        <= (w_nxt_state == S_ENABLE);
      r_ready     <= (w_nxt_state == S_IDLE) && w_nxt_done;
      r_busy      <= (w_nxt_state != S_IDLE);
    end
  end

  // RS/D come straight from the current-byte registers, which only load on SETUP entry.
  assign lcd_export = {r_en, 1'b0, r_rs, r_data};
  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign init_done  = r_init_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a per-cycle timeline model of the bus plus an EN-pulse
// byte queue, a command table, hand-written corner sequences and a randomized phase.
module tb_lcd_write_sequencer;
  localparam int T_PWRUP = 20;
  localparam int T_INIT1 = 10;
  localparam int T_INIT2 = 5;
  localparam int T_SU    = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 8;
  localparam int T_CLR   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rs = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        busy;
  logic        init_done;
  logic [10:0] lcd;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  lcd_write_sequencer #(
    .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SU(T_SU),
    .T_EN(T_EN), .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk_clk(clk), .reset_reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .busy(busy), .init_done(init_done),
    .lcd_export(lcd), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference timeline model ----------------
  logic [7:0] init_rom [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [8:0] exp_q[$];

  function automatic int user_wait(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_CLR;
    return T_CMD;
  endfunction

  function automatic int init_wait(input int idx);
    if (idx == 0) return T_INIT1;
    if (idx == 1) return T_INIT2;
    if (idx == 5) return T_CLR;
    return T_CMD;
  endfunction

  int         m_cyc = 0;
  bit         m_on = 0;
  bit         m_done;
  bit         m_pushed;
  int         m_idx, m_s, m_tw;
  logic       m_rs;
  logic [7:0] m_d;
  logic [8:0] m_prev;

  function automatic int m_end();
    return m_s + T_SU + T_EN + T_HOLD + m_tw;
  endfunction

  // Interval m_cyc is the stretch of time following posedge number m_cyc.
  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_on = 1; m_done = 0; m_prev = '0; m_idx = 0;
      m_s = m_cyc + T_PWRUP; m_rs = 1'b0; m_d = init_rom[0]; m_tw = init_wait(0);
      m_pushed = 0;
      exp_q.delete();
    end else if (m_on) begin
      if (!m_done && m_cyc >= m_end()) begin
        if (m_idx == 6) m_done = 1;
        else begin
          m_prev = {m_rs, m_d}; m_s = m_end(); m_idx++;
          m_d = init_rom[m_idx]; m_rs = 1'b0; m_tw = init_wait(m_idx); m_pushed = 0;
        end
      end else if (m_done && m_cyc - 1 >= m_end() && cmd_valid) begin
        m_prev = {m_rs, m_d}; m_s = m_cyc; m_rs = cmd_rs; m_d = cmd_data;
        m_tw = user_wait(cmd_rs, cmd_data); m_pushed = 0;
      end
      if (!m_pushed && m_cyc >= m_s) begin
        exp_q.push_back({m_rs, m_d});
        m_pushed = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the timeline.
  always @(negedge clk) begin
    if (m_on) begin
      automatic int   c = m_cyc;
      automatic bit   en_e = (c >= m_s + T_SU) && (c < m_s + T_SU + T_EN);
      automatic logic [8:0] rsd_e = (c < m_s) ? m_prev : {m_rs, m_d};
      automatic bit   rdy_e = m_done && (c >= m_end());
      chk("lcd_export", lcd, {en_e, 1'b0, rsd_e});
      chk("cmd_ready", cmd_ready, rdy_e);
      chk("busy", busy, !rdy_e);
      chk("init_done", init_done, m_done);
    end
  end

  // Scoreboard of bytes presented at each EN rising edge.
  int   en_cnt = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (lcd[10] && !prev_en) begin
      en_cnt++;
      if (exp_q.size() == 0) chk("en_unexpected", 1, 0);
      else chk("en_byte", lcd[8:0], exp_q.pop_front());
    end
    prev_en = lcd[10];
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en_cnt = 0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    if (!init_done) chk("init_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_en(input logic level);
    int n = 0;
    while (lcd[10] != level && n < 500) begin @(negedge clk); n++; end
    if (lcd[10] != level) chk("en_timeout", lcd[10], level);
  endtask

  // Sends one byte; returns the busy length and the bus value in the first SETUP cycle.
  task automatic send_measure(input logic rs, input logic [7:0] d,
                              output int n, output logic [10:0] setup_v);
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rs = 1'($urandom); cmd_data = 8'($urandom);
    setup_v = lcd;
    n = 0;
    while (!cmd_ready && n < 500) begin n++; @(negedge clk); end
  endtask

  // Cycles from the current interval until EN is seen high.
  task automatic cycles_to_en(output int n);
    n = 0;
    while (!lcd[10] && n < 200) begin n++; @(negedge clk); end
  endtask

  // ---------------- command table ----------------
  typedef struct {
    logic        rs;
    logic [7:0]  data;
    int          exp_cycles;
    logic [10:0] exp_setup;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int n, c0, rc;
    logic [10:0] sv;

    vecs[0] = '{1'b1, 8'h41, 16, 11'h141};
    vecs[1] = '{1'b0, 8'h01, 24, 11'h001};
    vecs[2] = '{1'b0, 8'h02, 24, 11'h002};
    vecs[3] = '{1'b0, 8'h03, 24, 11'h003};
    vecs[4] = '{1'b0, 8'h80, 16, 11'h080};
    vecs[5] = '{1'b1, 8'h01, 16, 11'h101};
    vecs[6] = '{1'b0, 8'h00, 16, 11'h000};
    vecs[7] = '{1'b0, 8'h04, 16, 11'h004};

    // Init sequence with cmd_valid poked during PWRUP.
    @(negedge clk);
    do_reset();
    chk("rst_lcd", lcd, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_init();
    chk("init_en_pulses", en_cnt, 7);

    for (int i = 0; i < 8; i++) begin
      send_measure(vecs[i].rs, vecs[i].data, n, sv);
      chk($sformatf("vec%0d_setup", i), sv, vecs[i].exp_setup);
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cycles);
    end

    // cmd_valid pulsed during WAIT is ignored.
    wait_ready();
    c0 = en_cnt;
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h80;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en(1'b1);
    wait_en(1'b0);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    chk("wait_poke_pulses", en_cnt - c0, 1);

    // Back-to-back with cmd_valid held: one IDLE cycle between the two writes.
    wait_ready();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h48;
    @(negedge clk);
    cmd_data = 8'h49;
    rc = 0; n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (cmd_ready) rc++;
      else if (rc > 0) break;
    end
    cmd_valid = 1'b0;
    chk("b2b_ready_cycles", rc, 1);
    wait_ready();

    // Randomized traffic; valid may be raised while busy and is held until accepted.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cmd_rs = 1'($urandom);
      cmd_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      cmd_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      cmd_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    end
    wait_ready();

    // Reset during ENABLE of a user write.
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en(1'b1);
    @(negedge clk);
    do_reset();
    chk("midop_lcd", lcd, 0);
    chk("midop_init_done", init_done, 0);
    chk("midop_busy", busy, 1);
    cycles_to_en(n);
    chk("midop_first_en", n, T_PWRUP + T_SU);
    wait_init();
    chk("midop_init_pulses", en_cnt, 7);

    // Reset during the init WAIT after entry 3.
    @(negedge clk);
    do_reset();
    n = 0;
    while (!(en_cnt == 3 && !lcd[10]) && n < 1000) begin @(negedge clk); n++; end
    chk("init3_reached", en_cnt, 3);
    repeat (T_HOLD + 2) @(negedge clk);
    do_reset();
    cycles_to_en(n);
    chk("init3_first_en", n, T_PWRUP + T_SU);
    chk("init3_first_byte", lcd[8:0], 9'h030);
    wait_init();
    chk("init3_init_pulses", en_cnt, 7);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
